// File: rtl/rbcp_initiator.sv
// rtl/rbcp_initiator.sv - RBCP bus master turning command bursts into RBCP byte transactions
// Optional ACK timeout/abort enabled by defining RBCP_INIT_TIMEOUT_EN.
module rbcp_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ACT_LEAD       = 2,
    parameter int ACT_TAIL       = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WE,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,
    input  logic        WD_VALID,
    output logic        WD_READY,
    input  logic [7:0]  WD_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_LAST,
    output logic        RSP_ERR,
    output logic        BUSY,
    output logic        RBCP_ACT,
    output logic [31:0] RBCP_ADDR,
    output logic        RBCP_WE,
    output logic [7:0]  RBCP_WD,
    output logic        RBCP_RE,
    input  logic [7:0]  RBCP_RD,
    input  logic        RBCP_ACK
);

    if (ACT_LEAD < 1 || ACT_LEAD > 15 || ACT_TAIL < 1 || ACT_TAIL > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("rbcp_initiator: parameter out of range");
    end

    localparam logic [3:0] LEAD_LAST = 4'(ACT_LEAD - 1);
    localparam logic [3:0] TAIL_LAST = 4'(ACT_TAIL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_ISSUE, S_WAIT_ACK, S_RESP, S_TAIL
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        we_mode;
    logic [31:0] addr;
    logic [7:0]  rem;
    logic [3:0]  phase_cnt;
    logic [7:0]  rsp_data_q;
    logic        rsp_last_q;
    logic        rsp_err_q;
    logic [31:0] rbcp_addr_q;
    logic [7:0]  rbcp_wd_q;
    logic        rbcp_we_q;
    logic        rbcp_re_q;

    logic        cmd_fire;
    logic        wd_fire;
    logic        rd_issue;
    logic        ack_ok;
    logic        rsp_fire;
    logic        timeout_hit;
    logic [31:0] issue_addr;

    assign cmd_fire = (state == S_IDLE) && CMD_VALID && !RST;
    assign wd_fire  = (state == S_ISSUE) && we_mode && WD_VALID;
    // Read strobes are launched on entry to ISSUE so the RE pulse is the ISSUE cycle itself.
    assign rd_issue = (state_nxt == S_ISSUE) && (state != S_ISSUE) && !we_mode;
    // A write strobe lands in the first WAIT_ACK cycle; an ACK in that cycle is too early.
    assign ack_ok   = (state == S_WAIT_ACK) && RBCP_ACK && !rbcp_we_q;
    assign rsp_fire = (state == S_RESP) && RSP_READY;
    // When re-issuing from RESP the address register is being bumped in the same edge.
    assign issue_addr = (state == S_RESP) ? (addr + 32'd1) : addr;

`ifdef RBCP_INIT_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // Cycles elapsed since the current strobe; zero in the strobe cycle itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt <= 16'd0;
        end else if (rd_issue || wd_fire) begin
            tmo_cnt <= 16'd0;
        end else if (state == S_WAIT_ACK || rbcp_re_q) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == S_WAIT_ACK) && !ack_ok && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (cmd_fire) state_nxt = S_LEAD;
            S_LEAD:     if (phase_cnt == LEAD_LAST) state_nxt = S_ISSUE;
            S_ISSUE:    if (!we_mode || WD_VALID) state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (ack_ok || timeout_hit) state_nxt = S_RESP;
            S_RESP:     if (RSP_READY) state_nxt = rsp_last_q ? S_TAIL : S_ISSUE;
            S_TAIL:     if (phase_cnt == TAIL_LAST) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; CMD_READY is also held low while reset is asserted.
    always_comb begin
        CMD_READY = 1'b0;
        WD_READY  = 1'b0;
        RSP_VALID = 1'b0;
        BUSY      = 1'b1;
        RBCP_ACT  = 1'b1;
        case (state)
            S_IDLE: begin
                CMD_READY = !RST;
                BUSY      = 1'b0;
                RBCP_ACT  = 1'b0;
            end
            S_ISSUE: WD_READY  = we_mode;
            S_RESP:  RSP_VALID = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping, strobe generation and response capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_mode     <= 1'b0;
            addr        <= 32'd0;
            rem         <= 8'd0;
            phase_cnt   <= 4'd0;
            rsp_data_q  <= 8'd0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rbcp_addr_q <= 32'd0;
            rbcp_wd_q   <= 8'd0;
            rbcp_we_q   <= 1'b0;
            rbcp_re_q   <= 1'b0;
        end else begin
            rbcp_we_q <= 1'b0;
            rbcp_re_q <= 1'b0;

            if (cmd_fire) begin
                we_mode <= CMD_WE;
                addr    <= CMD_ADDR;
                rem     <= CMD_LEN;
            end

            if (state_nxt != state) begin
                phase_cnt <= 4'd0;
            end else if (state == S_LEAD || state == S_TAIL) begin
                phase_cnt <= phase_cnt + 4'd1;
            end

            if (rsp_fire && !rsp_last_q) begin
                addr <= addr + 32'd1;
                rem  <= rem - 8'd1;
            end

            if (rd_issue) begin
                rbcp_re_q   <= 1'b1;
                rbcp_addr_q <= issue_addr;
            end

            if (wd_fire) begin
                rbcp_we_q   <= 1'b1;
                rbcp_wd_q   <= WD_DATA;
                rbcp_addr_q <= addr;
            end

            if (ack_ok) begin
                rsp_data_q <= we_mode ? 8'h00 : RBCP_RD;
                rsp_last_q <= (rem == 8'd0);
                rsp_err_q  <= 1'b0;
            end else if (timeout_hit) begin
                rsp_data_q <= 8'h00;
                rsp_last_q <= 1'b1;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign RSP_DATA  = rsp_data_q;
    assign RSP_LAST  = rsp_last_q;
    assign RSP_ERR   = rsp_err_q;
    assign RBCP_ADDR = rbcp_addr_q;
    assign RBCP_WD   = rbcp_wd_q;
    assign RBCP_WE   = rbcp_we_q;
    assign RBCP_RE   = rbcp_re_q;

endmodule
